// File: rtl/mood_pkg.sv
// Shared types and constants for the stimulus path of the mood model.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: arbiter state encoding, stimulus width, default hold/cooldown tick counts.
package mood_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_APPLY    = 2'd1,
    ST_COOLDOWN = 2'd2
  } arb_state_t;

  localparam int STIM_W                 = 7;
  localparam int CNT_W                  = 4;  // hold/cooldown counts are 0..15
  localparam int DEFAULT_HOLD_TICKS     = 4;
  localparam int DEFAULT_COOLDOWN_TICKS = 2;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin one-hot selector: first set bit of req at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to act on the pick.
// Ports: req (candidates), ptr (search start), onehot/idx (selected source), found (any candidate).
module rr_priority_picker #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            found
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      if (!found && req[(int'(ptr) + off) % NREQ]) begin
        found                               = 1'b1;
        idx                                 = IW'((int'(ptr) + off) % NREQ);
        onehot[(int'(ptr) + off) % NREQ]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stimulus_arbiter.sv
// Grants one stimulus source at a time and holds its vector for a number of model ticks, then cools down.
// Latency: gnt one cycle after an eligible req is seen in IDLE; stimuli_out one cycle after gnt.
// Backpressure: req is a level held by the source until gnt; ungranted requests are never queued.
// Ports: tick (model clock pulse), req/stim_in (per-source request and vector), sleeping/dead (physical state),
//        gnt (one-hot grant pulse), stimuli_out (applied vector), busy (APPLY or COOLDOWN).
module stimulus_arbiter
  import mood_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int HOLD_TICKS     = DEFAULT_HOLD_TICKS,
  parameter int COOLDOWN_TICKS = DEFAULT_COOLDOWN_TICKS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic [NREQ-1:0]          req,
  input  logic [STIM_W*NREQ-1:0]   stim_in,
  input  logic                     sleeping,
  input  logic                     dead,
  output logic [NREQ-1:0]          gnt,
  output logic [STIM_W-1:0]        stimuli_out,
  output logic                     busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t         state;
  logic [IW-1:0]      rr_ptr;
  logic [CNT_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]   cool_cnt;
  logic [STIM_W-1:0]  hold_reg;

  logic [NREQ-1:0]    eligible;
  logic [NREQ-1:0]    pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_found;

  // While asleep only the wake source (0) may be granted.
  assign eligible = sleeping ? (req & NREQ'(1)) : req;
  assign busy     = (state != ST_IDLE);

  rr_priority_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req    (eligible),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
      cool_cnt    <= '0;
      hold_reg    <= '0;
      gnt         <= '0;
      stimuli_out <= '0;
    end else begin
      gnt <= '0;
      if (dead) begin
        state       <= ST_IDLE;
        hold_cnt    <= '0;
        cool_cnt    <= '0;
        hold_reg    <= '0;
        stimuli_out <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            stimuli_out <= '0;
            if (pick_found) begin
              gnt      <= pick_onehot;
              hold_reg <= stim_in[pick_idx*STIM_W +: STIM_W];
              hold_cnt <= CNT_W'(HOLD_TICKS);
              rr_ptr   <= (pick_idx == IW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
              state    <= ST_APPLY;
            end
          end
          ST_APPLY: begin
            // gnt still high marks the grant cycle; a tick there is not counted.
            if (tick && (gnt == '0)) begin
              hold_cnt <= hold_cnt - 1'b1;
              if (hold_cnt == CNT_W'(1)) begin
                stimuli_out <= '0;
                if (COOLDOWN_TICKS == 0) begin
                  state <= ST_IDLE;
                end else begin
                  cool_cnt <= CNT_W'(COOLDOWN_TICKS);
                  state    <= ST_COOLDOWN;
                end
              end else begin
                stimuli_out <= hold_reg;
              end
            end else begin
              stimuli_out <= hold_reg;
            end
          end
          ST_COOLDOWN: begin
            stimuli_out <= '0;
            if (tick) begin
              cool_cnt <= cool_cnt - 1'b1;
              if (cool_cnt == CNT_W'(1)) begin
                state <= ST_IDLE;
              end
            end
          end
          default: begin
            state       <= ST_IDLE;
            stimuli_out <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stimulus_arbiter.sv
// Randomised and directed stimulus for stimulus_arbiter against a tick-budget reference model.
// Latency: n/a (bench).
// Backpressure: n/a (bench); requesters hold req until they see their gnt.
module tb_stimulus_arbiter;

  localparam int NREQ = 4;
  localparam int HOLD = 4;
  localparam int COOL = 2;

  logic                clk;
  logic                rst_n;
  logic                tick;
  logic [NREQ-1:0]     req;
  logic [7*NREQ-1:0]   stim_in;
  logic                sleeping;
  logic                dead;
  logic [NREQ-1:0]     gnt;
  logic [6:0]          stimuli_out;
  logic                busy;

  stimulus_arbiter #(
    .NREQ           (NREQ),
    .HOLD_TICKS     (HOLD),
    .COOLDOWN_TICKS (COOL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .req         (req),
    .stim_in     (stim_in),
    .sleeping    (sleeping),
    .dead        (dead),
    .gnt         (gnt),
    .stimuli_out (stimuli_out),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a granted source owns the output for a budget of HOLD
  // counted ticks, then a budget of COOL ticks of silence.
  int              m_ptr;
  bit              m_active;
  bit              m_first;
  int              m_apply_left;
  int              m_cool_left;
  logic [6:0]      m_val;
  logic [NREQ-1:0] exp_gnt;
  logic [6:0]      exp_stim;
  logic            exp_busy;

  task automatic model_reset();
    m_ptr = 0; m_active = 0; m_first = 0;
    m_apply_left = 0; m_cool_left = 0; m_val = '0;
    exp_gnt = '0; exp_stim = '0; exp_busy = 0;
  endtask

  task automatic model_step();
    logic [NREQ-1:0] elig;
    exp_gnt = '0;
    if (dead) begin
      m_active = 0; m_apply_left = 0; m_cool_left = 0; exp_stim = '0;
    end else if (!m_active) begin
      exp_stim = '0;
      elig = sleeping ? (req & NREQ'(1)) : req;
      for (int off = 0; off < NREQ; off++) begin
        int k;
        k = (m_ptr + off) % NREQ;
        if (exp_gnt == '0 && elig[k]) begin
          exp_gnt[k]   = 1'b1;
          m_val        = 7'(stim_in >> (7*k));
          m_active     = 1;
          m_first      = 1;
          m_apply_left = HOLD;
          m_cool_left  = COOL;
          m_ptr        = (k + 1) % NREQ;
        end
      end
    end else if (m_first) begin
      m_first  = 0;
      exp_stim = m_val;
    end else if (m_apply_left > 0) begin
      if (tick) m_apply_left--;
      if (m_apply_left > 0) exp_stim = m_val;
      else begin
        exp_stim = '0;
        if (m_cool_left == 0) m_active = 0;
      end
    end else begin
      exp_stim = '0;
      if (tick) m_cool_left--;
      if (m_cool_left == 0) m_active = 0;
    end
    exp_busy = m_active;
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic cycle(input logic [NREQ-1:0] r, input logic [7*NREQ-1:0] s,
                       input logic t, input logic sl, input logic d);
    req = r; stim_in = s; tick = t; sleeping = sl; dead = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("gnt", gnt, exp_gnt);
    chk("stim", stimuli_out, exp_stim);
    chk("busy", busy, exp_busy);
  endtask

  task automatic do_reset();
    req = '0; stim_in = '0; tick = 0; sleeping = 0; dead = 0;
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_gnt", gnt, '0);
    chk("rst_stim", stimuli_out, '0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  localparam logic [27:0] S05   = 28'h0000005;
  localparam logic [27:0] SDIST = {7'h13, 7'h12, 7'h11, 7'h10};

  initial begin
    int n;
    int ng;
    int order_got[5];
    int order_exp[5];
    logic [NREQ-1:0] r;
    logic sl;
    order_exp = '{0, 1, 2, 3, 0};
    rst_n = 0;
    do_reset();

    // Basic hold/cooldown budget with a single source.
    cycle(4'b0001, S05, 0, 0, 0);
    chk("t1_gnt", gnt, 4'b0001);
    cycle(4'b0000, S05, 0, 0, 0);
    chk("t1_stim", stimuli_out, 7'h05);
    n = 0;
    while (stimuli_out != 0 && n < 20) begin
      cycle(4'b0000, S05, 0, 0, 0);
      cycle(4'b0000, S05, 1, 0, 0);
      n++;
    end
    chk("t1_hold_ticks", n, HOLD);
    n = 0;
    while (busy && n < 20) begin
      cycle(4'b0000, S05, 1, 0, 0);
      n++;
    end
    chk("t1_cool_ticks", n, COOL);
    chk("t1_idle_busy", busy, 1'b0);

    // Round-robin order with every source requesting.
    do_reset();
    ng = 0;
    for (int c = 0; c < 80 && ng < 5; c++) begin
      cycle(4'b1111, SDIST, 1, 0, 0);
      for (int b = 0; b < NREQ; b++)
        if (gnt[b] && ng < 5) begin
          order_got[ng] = b;
          ng++;
        end
    end
    chk("rr_count", ng, 5);
    for (int i = 0; i < 5; i++)
      if (i < ng) chk("rr_order", order_got[i], order_exp[i]);

    // Sleeping: only the wake source may be granted.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1110, SDIST, 0, 1, 0);
      chk("sleep_nognt", gnt, 4'b0000);
    end
    cycle(4'b1111, SDIST, 0, 1, 0);
    chk("sleep_wake_gnt", gnt, 4'b0001);
    for (int i = 0; i < 12; i++) cycle(4'b1110, SDIST, 1, 0, 0);

    // Dead during APPLY, then requests held while dead.
    do_reset();
    cycle(4'b0001, S05, 0, 0, 0);
    cycle(4'b0000, S05, 1, 0, 0);
    cycle(4'b0000, S05, 1, 0, 0);
    cycle(4'b0000, S05, 1, 0, 0);
    chk("dead_pre_stim", stimuli_out, 7'h05);
    cycle(4'b0000, S05, 0, 0, 1);
    chk("dead_busy", busy, 1'b0);
    chk("dead_stim", stimuli_out, 7'h00);
    for (int i = 0; i < 4; i++) begin
      cycle(4'b1111, S05, 0, 0, 1);
      chk("dead_nognt", gnt, 4'b0000);
    end

    // Tick in the decision and grant cycles is not counted.
    do_reset();
    cycle(4'b0001, S05, 1, 0, 0);
    cycle(4'b0000, S05, 1, 0, 0);
    chk("coin_stim", stimuli_out, 7'h05);
    n = 0;
    while (stimuli_out != 0 && n < 20) begin
      cycle(4'b0000, S05, 1, 0, 0);
      n++;
    end
    chk("coin_hold_ticks", n, HOLD);
    for (int i = 0; i < 4; i++) cycle(4'b0000, S05, 1, 0, 0);

    // Reset asserted mid-APPLY.
    do_reset();
    cycle(4'b0001, S05, 0, 0, 0);
    cycle(4'b0000, S05, 0, 0, 0);
    cycle(4'b0000, S05, 1, 0, 0);
    chk("pre_rst_stim", stimuli_out, 7'h05);
    #2 rst_n = 0;
    #1;
    chk("arst_gnt", gnt, '0);
    chk("arst_stim", stimuli_out, '0);
    chk("arst_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cycle(4'b1010, SDIST, 0, 0, 0);
    chk("rst_regrant", gnt, 4'b0010);

    // Randomised traffic; requesters hold until granted.
    r  = '0;
    sl = 0;
    for (int c = 0; c < 500; c++) begin
      r = r & ~gnt;
      if ($urandom_range(0, 3) == 0) r = r | NREQ'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) r = r & NREQ'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) sl = ~sl;
      cycle(r, 28'($urandom()), ($urandom_range(0, 9) < 4), sl,
            ($urandom_range(0, 39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stimulus_arbiter.md
STIMULUS_ARBITER -- requirements
Module: stimulus_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of stimulus requesters.
REQ-002 Parameter HOLD_TICKS, default 4: model ticks a granted stimulus stays applied, range 1..15.
REQ-003 Parameter COOLDOWN_TICKS, default 2: model ticks of forced-zero stimulus after each apply, range 0..15.
REQ-004 clk  in  1  system clock, single clock domain.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 tick  in  1  one-cycle pulse marking a model-clock update, from the heartbeat divider.
REQ-007 req  in  NREQ  level request per source, held until that source's gnt.
REQ-008 stim_in  in  7*NREQ  stimulus vector per source, slice i = bits [7i+6:7i].
REQ-009 sleeping  in  1  physical state is asleep.
REQ-010 dead  in  1  energy counter at zero.
REQ-011 gnt  out  NREQ  one-hot, one-cycle grant pulse.
REQ-012 stimuli_out  out  7  stimulus vector to the stress and pleasure regulators.
REQ-013 busy  out  1  high in APPLY or COOLDOWN.

Function
REQ-014 States: IDLE, APPLY, COOLDOWN; 2-bit encoding.
REQ-015 IDLE: if dead=0 and an eligible req exists, the arbiter latches that source's stim_in into the hold register, pulses its gnt for exactly that cycle, loads hold_cnt=HOLD_TICKS, and enters APPLY on the next cycle.
REQ-016 Eligibility: all sources when sleeping=0; only source 0 (wake source) when sleeping=1.
REQ-017 Round-robin: the search starts at rr_ptr; after a grant to source k, rr_ptr=(k+1) mod NREQ; rr_ptr is unchanged when no grant occurs.
REQ-018 APPLY: stimuli_out=hold register; each tick decrements hold_cnt; the tick that takes hold_cnt 1->0 enters COOLDOWN with cool_cnt=COOLDOWN_TICKS, or IDLE if COOLDOWN_TICKS=0.
REQ-019 COOLDOWN: stimuli_out=0; each tick decrements cool_cnt; the tick that takes 1->0 enters IDLE.
REQ-020 stimuli_out=0 in IDLE, including the grant cycle; it first shows the new value one cycle after gnt.
REQ-021 Ticks arriving in IDLE are ignored; a tick coincident with a grant is not counted toward HOLD_TICKS.
REQ-022 dead=1 in any state: next cycle is IDLE with hold register cleared and stimuli_out=0; no gnt is issued while dead=1.
REQ-023 sleeping rising during APPLY: the current stimulus completes normally; eligibility is re-evaluated only in IDLE.
REQ-024 A req dropped before grant is lost silently; req for an ungranted source is never queued internally.
REQ-025 gnt is all-zero outside the single grant cycle and has at most one bit set.
REQ-026 busy is combinational from state; gnt and stimuli_out are registered.

Reset
REQ-027 rst_n low asynchronously forces: state=IDLE, rr_ptr=0, hold_cnt=0, cool_cnt=0, hold register=0, gnt=0, stimuli_out=0, busy=0.
REQ-028 Assertion mid-APPLY drops the stimulus without a cooldown; after deassertion, the first grant needs one full clk cycle in IDLE.

Structure
REQ-029 The state encoding, the stimulus width constant (7), and the default HOLD/COOLDOWN values live in the shared mood package.
REQ-030 One sub-module, rr_priority_picker (NREQ-wide masked round-robin one-hot select), is instantiated once; the FSM and counters stay in stimulus_arbiter.

Verification
REQ-031 The bench SHALL cover:
- req=0001, stim0=7'h05, then 4 ticks -> gnt=0001 for 1 cycle, stimuli_out=05 for exactly 4 ticks, then 0 for 2 ticks, then IDLE with busy=0.
- req=1111 held with rr_ptr=0 -> grants in the order 0,1,2,3,0 across successive IDLE entries.
- sleeping=1 with req=1110 -> no gnt; req0 raised -> gnt=0001 next cycle.
- dead pulsed during APPLY after 2 ticks -> next cycle IDLE, stimuli_out=0; req held with dead=1 -> gnt stays 0.
- Tick coincident with the grant cycle -> stimuli_out still held for 4 subsequent ticks.
- rst_n asserted mid-APPLY -> all outputs 0 immediately; after release, rr_ptr=0 and the next grant goes to the lowest active req.
